branch_resolve_feedback: RTL and testbench
==========================================

Name: branch_resolve_feedback

Overview:
- Producer side of the predictor feedback interface: generates feedback_valid / prediction_correct for the 2-bit saturating counter, plus a fetch redirect.
- Records each prediction made at IF in an in-order in-flight queue.
- When EX resolves the oldest branch, compares the actual outcome against the recorded prediction, emits registered feedback, and flushes wrong-path entries on a mispredict.

Parameters:
- DEPTH, 4, max in-flight predicted branches (power of 2, >=2)
- ADDR_W, 32, PC width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pred_valid  in  1  IF issued a branch prediction this cycle
- pred_taken  in  1  predicted direction (counter's take_branch)
- pred_target  in  ADDR_W  predicted-taken target
- pred_fallthru  in  ADDR_W  sequential PC (branch PC + 4)
- pred_ready  out  1  queue not full; IF stalls when low
- res_valid  in  1  EX resolved the oldest in-flight branch this cycle
- res_taken  in  1  actual direction
- res_target  in  ADDR_W  actual taken target
- feedback_valid  out  1  feedback pulse to the saturating counter
- prediction_correct  out  1  direction matched; qualified by feedback_valid
- redirect_valid  out  1  fetch must restart at redirect_pc
- redirect_pc  out  ADDR_W  restart PC
- inflight_cnt  out  $clog2(DEPTH+1)  occupancy
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0): queue empty, inflight_cnt=0, pred_ready=1, feedback_valid=0, prediction_correct=0, redirect_valid=0, redirect_pc=0, err=0. Reset mid-operation discards all entries immediately.
- Push: pred_valid && pred_ready writes {pred_taken, pred_target, pred_fallthru} at the tail.
- pred_ready = (inflight_cnt < DEPTH), derived from registered state only; no same-cycle pop bypass.
- Pop: res_valid && inflight_cnt != 0 compares against the head entry.
  - dir_ok = (res_taken == head.taken).
  - tgt_ok = !res_taken || (head.target == res_target).
  - mispredict = !(dir_ok && tgt_ok).
- Outputs, registered, valid exactly 1 cycle after the res_valid edge:
  - feedback_valid=1, prediction_correct=dir_ok (direction only; a target-only miss still reports correct).
  - redirect_valid=mispredict; redirect_pc = res_taken ? res_target : head.fallthru.
  - All pulses are single-cycle; return to 0 when no resolution occurs.
- Mispredict flush: at the resolving edge the whole queue empties (head popped, all younger entries are wrong-path); inflight_cnt=0 next cycle.
- Simultaneous push + mispredict pop: push discarded (wrong-path).
- Simultaneous push + correct pop: both occur; count unchanged; pointers advance.
- Push when pred_ready=0: ignored, err set.
- res_valid with inflight_cnt=0: ignored, no feedback, err set.
- err clears only on reset.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is a separate register (full vs empty unambiguous).
- Arithmetic: unsigned PC compare, full ADDR_W.

Decomposition:
- Shared package: ADDR_W default; typedef bp_entry_t {taken, target[ADDR_W], fallthru[ADDR_W]}; localparam ENTRY_W = 2*ADDR_W+1.
- One natural sub-module, branch_inflight_fifo: synchronous-write FIFO with push/pop/clear, count, and head read.
- Compare, output registers, and err stay in the top.

Test Plan:
- Reset then push {taken=1, tgt=0x100, ft=0x44}; res_valid taken=1, tgt=0x100 -> next cycle feedback_valid=1, prediction_correct=1, redirect_valid=0, inflight_cnt=0.
- Push {taken=0, ft=0x48}; resolve taken=1, tgt=0x200 -> prediction_correct=0, redirect_valid=1, redirect_pc=0x200.
- Push {taken=1, tgt=0x300, ft=0x50}; resolve taken=0 -> prediction_correct=0, redirect_pc=0x50.
- Push {taken=1, tgt=0x300}; resolve taken=1, tgt=0x304 -> prediction_correct=1, redirect_valid=1, redirect_pc=0x304.
- Fill 4 entries -> pred_ready=0. Fifth push -> err=1, count stays 4. Resolve head mispredicted while pushing -> count=0, push dropped.
- Queue at 2; assert rst_n=0 asynchronously mid-cycle -> count=0, pred_ready=1, all outputs 0 before the next edge. Then res_valid with an empty queue -> no feedback, err=1.

Source files
------------

// File: rtl/branch_resolve_feedback_pkg.sv
// Shared types for branch resolution feedback: the in-flight prediction record.
package branch_resolve_feedback_pkg;

    localparam int BP_ADDR_W = 32;
    localparam int ENTRY_W   = 2 * BP_ADDR_W + 1;

    typedef struct packed {
        logic                 taken;
        logic [BP_ADDR_W-1:0] target;
        logic [BP_ADDR_W-1:0] fallthru;
    } bp_entry_t;

endpackage

// File: rtl/branch_resolve_feedback_if.sv
// IF prediction, EX resolution and predictor/fetch feedback signals.
interface branch_resolve_feedback_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              pred_valid;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [ADDR_W-1:0] pred_fallthru;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              feedback_valid;
    logic              prediction_correct;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  inflight_cnt;
    logic              err;

    modport master (
        output pred_valid, pred_taken, pred_target, pred_fallthru,
        output res_valid, res_taken, res_target,
        input  pred_ready, feedback_valid, prediction_correct,
        input  redirect_valid, redirect_pc, inflight_cnt, err
    );

    modport slave (
        input  pred_valid, pred_taken, pred_target, pred_fallthru,
        input  res_valid, res_taken, res_target,
        output pred_ready, feedback_valid, prediction_correct,
        output redirect_valid, redirect_pc, inflight_cnt, err
    );

endinterface

// File: rtl/branch_inflight_fifo.sv
// In-order queue of outstanding predictions; clear drops everything at once.
// Caller guarantees no push when full and no pop when empty.
module branch_inflight_fifo
    import branch_resolve_feedback_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  bp_entry_t        din,
    output bp_entry_t        head,
    output logic [CNT_W-1:0] count
);

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage; no reset needed since count qualifies every read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of 2); count kept separately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_feedback.sv
// Tracks predictions made at IF, checks them when EX resolves the oldest one,
// and produces registered counter feedback plus a fetch redirect.
module branch_resolve_feedback
    import branch_resolve_feedback_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = BP_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_resolve_feedback_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    bp_entry_t         head;
    bp_entry_t         din;
    logic [CNT_W-1:0]  cnt;
    logic              pred_ready;
    logic              res_fire;
    logic              dir_ok;
    logic              tgt_ok;
    logic              mispredict;
    logic              flush;
    logic              pop;
    logic              push;
    logic              feedback_valid_q;
    logic              prediction_correct_q;
    logic              redirect_valid_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic              err_q;

    // Ready is from registered occupancy only; a same-cycle pop does not free a slot.
    assign pred_ready = (cnt < CNT_W'(DEPTH));
    assign res_fire   = bus.res_valid && (cnt != '0);
    assign dir_ok     = (bus.res_taken == head.taken);
    assign tgt_ok     = !bus.res_taken || (head.target == bus.res_target);
    assign mispredict = !(dir_ok && tgt_ok);
    // On a mispredict everything younger than the head is wrong-path, including
    // a prediction arriving in the same cycle.
    assign flush      = res_fire && mispredict;
    assign pop        = res_fire && !mispredict;
    assign push       = bus.pred_valid && pred_ready && !flush;

    assign din.taken    = bus.pred_taken;
    assign din.target   = bus.pred_target;
    assign din.fallthru = bus.pred_fallthru;

    branch_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (din),
        .head  (head),
        .count (cnt)
    );

    // Single-cycle feedback/redirect pulses, registered one cycle after resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feedback_valid_q     <= 1'b0;
            prediction_correct_q <= 1'b0;
            redirect_valid_q     <= 1'b0;
            redirect_pc_q        <= '0;
        end else begin
            feedback_valid_q     <= res_fire;
            prediction_correct_q <= res_fire && dir_ok;
            redirect_valid_q     <= flush;
            if (res_fire) begin
                redirect_pc_q <= bus.res_taken ? bus.res_target : head.fallthru;
            end else begin
                redirect_pc_q <= '0;
            end
        end
    end

    // Sticky protocol error: push into a full queue or resolve with nothing in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((bus.pred_valid && !pred_ready) || (bus.res_valid && (cnt == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.pred_ready         = pred_ready;
    assign bus.inflight_cnt       = cnt;
    assign bus.feedback_valid     = feedback_valid_q;
    assign bus.prediction_correct = prediction_correct_q;
    assign bus.redirect_valid     = redirect_valid_q;
    assign bus.redirect_pc        = redirect_pc_q;
    assign bus.err                = err_q;

endmodule

// File: tb/tb_branch_resolve_feedback.sv
// Self-checking bench for branch_resolve_feedback against a queue-based model.
module tb_branch_resolve_feedback;
    import branch_resolve_feedback_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = BP_ADDR_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_feedback_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    branch_resolve_feedback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bp_entry_t         m_q[$];
    bit                m_err;
    bit                e_fb, e_pc, e_rv;
    logic [ADDR_W-1:0] e_rpc;

    // Drive one cycle of stimulus (called at negedge), update the model, land on next negedge.
    task automatic drive(input bit pv, input bit pt, input logic [ADDR_W-1:0] ptgt,
                         input logic [ADDR_W-1:0] pft, input bit rv, input bit rt,
                         input logic [ADDR_W-1:0] rtgt);
        bit        flushed;
        bit        was_ready;
        bp_entry_t h;
        bp_entry_t n;
        bus.pred_valid    = pv;
        bus.pred_taken    = pt;
        bus.pred_target   = ptgt;
        bus.pred_fallthru = pft;
        bus.res_valid     = rv;
        bus.res_taken     = rt;
        bus.res_target    = rtgt;
        flushed   = 0;
        was_ready = (m_q.size() < DEPTH);
        e_fb = 0; e_pc = 0; e_rv = 0; e_rpc = '0;
        if (rv) begin
            if (m_q.size() == 0) begin
                m_err = 1;
            end else begin
                h     = m_q.pop_front();
                e_fb  = 1;
                e_pc  = (rt == h.taken);
                e_rv  = !e_pc || (rt && (h.target != rtgt));
                e_rpc = rt ? rtgt : h.fallthru;
                if (e_rv) begin
                    flushed = 1;
                    m_q.delete();
                end
            end
        end
        if (pv) begin
            if (!was_ready) m_err = 1;
            else if (!flushed) begin
                n.taken = pt; n.target = ptgt; n.fallthru = pft;
                m_q.push_back(n);
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete(); m_err = 0;
        @(negedge clk);
        n_checks++;
        if (bus.inflight_cnt !== '0 || bus.pred_ready !== 1'b1 || bus.feedback_valid !== 1'b0 ||
            bus.prediction_correct !== 1'b0 || bus.redirect_valid !== 1'b0 ||
            bus.redirect_pc !== '0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d rdy=%0b fb=%0b pc=%0b rv=%0b rpc=%h err=%0b, required all zero with rdy=1",
                     bus.inflight_cnt, bus.pred_ready, bus.feedback_valid, bus.prediction_correct,
                     bus.redirect_valid, bus.redirect_pc, bus.err);
        end
    endtask

    typedef struct {
        bit                pt;
        logic [ADDR_W-1:0] ptgt;
        logic [ADDR_W-1:0] pft;
        bit                rt;
        logic [ADDR_W-1:0] rtgt;
    } scen_t;

    task automatic test_resolve_table();
        scen_t tbl[4];
        tbl[0] = '{1'b1, 32'h100, 32'h44, 1'b1, 32'h100};
        tbl[1] = '{1'b0, 32'h0,   32'h48, 1'b1, 32'h200};
        tbl[2] = '{1'b1, 32'h300, 32'h50, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 32'h300, 32'h54, 1'b1, 32'h304};
        for (int i = 0; i < 4; i++) begin
            drive(1, tbl[i].pt, tbl[i].ptgt, tbl[i].pft, 0, 0, '0);
            n_checks++;
            if (bus.inflight_cnt !== CNT_W'(1)) begin
                n_fail++;
                $display("FAIL table%0d_push_cnt: got %0d want 1", i, bus.inflight_cnt);
            end
            drive(0, 0, '0, '0, 1, tbl[i].rt, tbl[i].rtgt);
            n_checks++;
            if (bus.feedback_valid !== e_fb || bus.prediction_correct !== e_pc ||
                bus.redirect_valid !== e_rv || bus.redirect_pc !== e_rpc ||
                bus.inflight_cnt !== CNT_W'(m_q.size())) begin
                n_fail++;
                $display("FAIL table%0d_resolve: fb=%0b pc=%0b rv=%0b rpc=%h cnt=%0d want fb=%0b pc=%0b rv=%0b rpc=%h cnt=%0d",
                         i, bus.feedback_valid, bus.prediction_correct, bus.redirect_valid,
                         bus.redirect_pc, bus.inflight_cnt, e_fb, e_pc, e_rv, e_rpc, m_q.size());
            end
            @(negedge clk);
            n_checks++;
            if (bus.feedback_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL table%0d_pulse_width: fb=%0b rv=%0b want 0 0", i,
                         bus.feedback_valid, bus.redirect_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 32'h400, 32'h60, 0, 0, '0);
        drive(1, 0, 32'h0,   32'h64, 0, 0, '0);
        drive(1, 1, 32'h500, 32'h68, 1, 1, 32'h400);
        n_checks++;
        if (bus.inflight_cnt !== CNT_W'(2) || bus.feedback_valid !== 1'b1 ||
            bus.prediction_correct !== 1'b1 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_same_cycle: cnt=%0d fb=%0b pc=%0b rv=%0b want cnt=2 fb=1 pc=1 rv=0",
                     bus.inflight_cnt, bus.feedback_valid, bus.prediction_correct, bus.redirect_valid);
        end
        drive(0, 0, '0, '0, 1, 0, '0);
        drive(0, 0, '0, '0, 1, 1, 32'h500);
        n_checks++;
        if (bus.inflight_cnt !== '0 || bus.prediction_correct !== 1'b1 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_order: cnt=%0d pc=%0b rv=%0b want cnt=0 pc=1 rv=0",
                     bus.inflight_cnt, bus.prediction_correct, bus.redirect_valid);
        end
    endtask

    task automatic test_full_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 32'h700 + 32'(i * 16), 32'h80 + 32'(i * 4), 0, 0, '0);
        end
        n_checks++;
        if (bus.pred_ready !== 1'b0 || bus.inflight_cnt !== CNT_W'(DEPTH) || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: rdy=%0b cnt=%0d err=%0b want rdy=0 cnt=%0d err=0",
                     bus.pred_ready, bus.inflight_cnt, bus.err, DEPTH);
        end
        drive(1, 0, 32'h0, 32'h90, 0, 0, '0);
        n_checks++;
        if (bus.err !== 1'b1 || bus.inflight_cnt !== CNT_W'(DEPTH)) begin
            n_fail++;
            $display("FAIL push_when_full: err=%0b cnt=%0d want err=1 cnt=%0d",
                     bus.err, bus.inflight_cnt, DEPTH);
        end
        drive(1, 0, 32'h0, 32'h94, 1, 0, '0);
        n_checks++;
        if (bus.inflight_cnt !== '0 || bus.pred_ready !== 1'b1 || bus.redirect_valid !== 1'b1 ||
            bus.redirect_pc !== 32'h80 || bus.prediction_correct !== 1'b0) begin
            n_fail++;
            $display("FAIL mispredict_flush: cnt=%0d rdy=%0b rv=%0b rpc=%h pc=%0b want cnt=0 rdy=1 rv=1 rpc=80 pc=0",
                     bus.inflight_cnt, bus.pred_ready, bus.redirect_valid, bus.redirect_pc,
                     bus.prediction_correct);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (m_q.size() < 3 && guard < 10) begin
            drive(1, 0, '0, 32'hA00 + 32'(guard * 4), 0, 0, '0);
            guard++;
        end
        drive(0, 0, '0, '0, 1, m_q[0].taken, m_q[0].target);
        n_checks++;
        if (bus.feedback_valid !== 1'b1 || bus.inflight_cnt !== CNT_W'(2)) begin
            n_fail++;
            $display("FAIL pre_reset_state: fb=%0b cnt=%0d want fb=1 cnt=2",
                     bus.feedback_valid, bus.inflight_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        m_q.delete(); m_err = 0;
        n_checks++;
        if (bus.inflight_cnt !== '0 || bus.pred_ready !== 1'b1 || bus.feedback_valid !== 1'b0 ||
            bus.prediction_correct !== 1'b0 || bus.redirect_valid !== 1'b0 ||
            bus.redirect_pc !== '0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cnt=%0d rdy=%0b fb=%0b pc=%0b rv=%0b rpc=%h err=%0b want all zero rdy=1",
                     bus.inflight_cnt, bus.pred_ready, bus.feedback_valid, bus.prediction_correct,
                     bus.redirect_valid, bus.redirect_pc, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 1, 32'h123);
        n_checks++;
        if (bus.feedback_valid !== 1'b0 || bus.err !== 1'b1 || bus.inflight_cnt !== '0) begin
            n_fail++;
            $display("FAIL resolve_empty: fb=%0b err=%0b cnt=%0d want fb=0 err=1 cnt=0",
                     bus.feedback_valid, bus.err, bus.inflight_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit                pv, pt, rv, rt;
            logic [ADDR_W-1:0] ptgt, pft, rtgt;
            pv   = ($urandom_range(0, 9) < 6);
            pt   = 1'($urandom_range(0, 1));
            ptgt = 32'h1000 + 32'(4 * $urandom_range(0, 3));
            pft  = 32'($urandom);
            rv   = ($urandom_range(0, 9) < 5);
            rt   = 1'($urandom_range(0, 1));
            rtgt = 32'h1000 + 32'(4 * $urandom_range(0, 3));
            drive(pv, pt, ptgt, pft, rv, rt, rtgt);
            n_checks++;
            if (bus.feedback_valid !== e_fb || bus.redirect_valid !== e_rv ||
                bus.inflight_cnt !== CNT_W'(m_q.size()) ||
                bus.pred_ready !== (m_q.size() < DEPTH) || bus.err !== m_err ||
                (e_fb && (bus.prediction_correct !== e_pc || bus.redirect_pc !== e_rpc))) begin
                n_fail++;
                $display("FAIL random%0d: fb=%0b pc=%0b rv=%0b rpc=%h cnt=%0d rdy=%0b err=%0b want fb=%0b pc=%0b rv=%0b rpc=%h cnt=%0d err=%0b",
                         i, bus.feedback_valid, bus.prediction_correct, bus.redirect_valid,
                         bus.redirect_pc, bus.inflight_cnt, bus.pred_ready, bus.err,
                         e_fb, e_pc, e_rv, e_rpc, m_q.size(), m_err);
            end
        end
    endtask

    initial begin
        bus.pred_valid    = 1'b0;
        bus.pred_taken    = 1'b0;
        bus.pred_target   = '0;
        bus.pred_fallthru = '0;
        bus.res_valid     = 1'b0;
        bus.res_taken     = 1'b0;
        bus.res_target    = '0;
        m_err = 0;
        test_reset();
        test_resolve_table();
        test_back_to_back();
        test_full_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
